// File: rtl/bit_serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, with start/busy/done control.
// Optional compare flags (eq, lt_u, lt_s) enabled by defining BSS_COMPARE_EN.
module bit_serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             res,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf
`ifdef BSS_COMPARE_EN
   ,
   output logic             eq,
   output logic             lt_u,
   output logic             lt_s
`endif
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t          state, state_n;
   logic            load, step, last;
   logic [WIDTH-1:0] sa, sb;
   logic [CW-1:0]   cnt;
   logic            bin;
   logic            a0, b0, d, bout;

   assign a0   = sa[0];
   assign b0   = sb[0];
   assign d    = a0 ^ b0 ^ bin;
   assign bout = (~a0 & b0) | (~(a0 ^ b0) & bin);
   assign last = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (res) state <= IDLE;
      else     state <= state_n;
   end

   // A non-1 start (including X) falls through to the no-request branch.
   always_comb begin
      state_n = state;
      load    = 1'b0;
      step    = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state)
         IDLE: begin
            if (start == 1'b1) begin
               load    = 1'b1;
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            step = 1'b1;
            if (last) state_n = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start == 1'b1) begin
               load    = 1'b1;
               state_n = SHIFT;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

`ifdef BSS_COMPARE_EN
   logic nz;
`endif

   always_ff @(posedge clk) begin
      if (res) begin
         sa     <= '0;
         sb     <= '0;
         cnt    <= '0;
         bin    <= 1'b0;
         diff   <= '0;
         borrow <= 1'b0;
         ovf    <= 1'b0;
`ifdef BSS_COMPARE_EN
         nz     <= 1'b0;
         eq     <= 1'b0;
         lt_u   <= 1'b0;
         lt_s   <= 1'b0;
`endif
      end else if (load) begin
         // borrow/ovf (and compare flags) hold until the new result lands
         sa   <= a;
         sb   <= b;
         cnt  <= '0;
         bin  <= 1'b0;
         diff <= '0;
`ifdef BSS_COMPARE_EN
         nz   <= 1'b0;
`endif
      end else if (step) begin
         sa   <= sa >> 1;
         sb   <= sb >> 1;
         cnt  <= cnt + 1'b1;
         bin  <= bout;
         diff <= {d, diff[WIDTH-1:1]};
`ifdef BSS_COMPARE_EN
         nz   <= nz | d;
`endif
         if (last) begin
            borrow <= bout;
            ovf    <= bin ^ bout;
`ifdef BSS_COMPARE_EN
            eq     <= ~(nz | d);
            lt_u   <= bout;
            lt_s   <= d ^ (bin ^ bout);
`endif
         end
      end
   end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Self-checking bench for bit_serial_subtractor (WIDTH=8): vector table plus
// reset-abort and back-to-back sequences; compare flags checked when BSS_COMPARE_EN is set.
module tb_bit_serial_subtractor;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         res, start;
   logic [W-1:0] a, b;
   logic         busy, done, borrow, ovf;
   logic [W-1:0] diff;
`ifdef BSS_COMPARE_EN
   logic         eq, lt_u, lt_s;
`endif

   int checks   = 0;
   int failures = 0;

   bit_serial_subtractor #(.WIDTH(W)) dut (
      .clk(clk), .res(res), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .diff(diff), .borrow(borrow), .ovf(ovf)
`ifdef BSS_COMPARE_EN
      , .eq(eq), .lt_u(lt_u), .lt_s(lt_s)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a, b, diff;
      logic         borrow, ovf, eq, lt_u, lt_s;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Launch one operation and follow it to done; returns latency and busy count.
   task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                         output int lat, output int nbusy, output logic done_next);
      lat = 0; nbusy = 0;
      @(negedge clk);
      a = va; b = vb; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = 8'hA5; b = 8'h3C;
      for (int k = 1; k <= 30; k++) begin
         if (k > 1) @(negedge clk);
         if (busy) nbusy++;
         if (done) begin
            lat = k;
            break;
         end
      end
      @(negedge clk);
      done_next = done;
      @(posedge clk); #1;
   endtask

   initial begin
      int lat, nbusy, ndone;
      logic dn;
      vecs[0] = '{8'h35, 8'h12, 8'h23, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{8'h12, 8'h35, 8'hDD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[5] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

      res = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      res = 1'b0;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_diff", diff, 0);
      chk("reset_borrow", borrow, 0);
      chk("reset_ovf", ovf, 0);
`ifdef BSS_COMPARE_EN
      chk("reset_eq", eq, 0);
`endif

      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i].a, vecs[i].b, lat, nbusy, dn);
         chk("latency", lat, 9);
         chk("busy_cycles", nbusy, 8);
         chk("done_one_cycle", dn, 0);
         chk("diff", diff, vecs[i].diff);
         chk("borrow", borrow, vecs[i].borrow);
         chk("ovf", ovf, vecs[i].ovf);
`ifdef BSS_COMPARE_EN
         chk("eq", eq, vecs[i].eq);
         chk("lt_u", lt_u, vecs[i].lt_u);
         chk("lt_s", lt_s, vecs[i].lt_s);
`endif
      end

      // Abort by reset mid-operation; previous result had borrow=1, ovf=1.
      @(negedge clk);
      a = 8'h35; b = 8'h12; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      a = 8'hFF; start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("start_ignored_busy", busy, 1);
      @(negedge clk);
      res = 1'b1;
      @(negedge clk);
      res = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_diff", diff, 0);
      chk("abort_borrow", borrow, 0);
      chk("abort_ovf", ovf, 0);
      ndone = 0;
      for (int k = 0; k < 12; k++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      chk("abort_no_done", ndone, 0);
      run_op(8'h10, 8'h01, lat, nbusy, dn);
      chk("after_abort_latency", lat, 9);
      chk("after_abort_diff", diff, 8'h0F);

      // Back-to-back: 0x12-0x35 (borrow=1), start held through done with 0x09-0x03.
      @(negedge clk);
      a = 8'h12; b = 8'h35; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k < 8; k++) @(negedge clk);
      chk("b2b_busy_k8", busy, 1);
      a = 8'h09; b = 8'h03; start = 1'b1;
      @(negedge clk);
      chk("b2b_done1", done, 1);
      chk("b2b_diff1", diff, 8'hDD);
      chk("b2b_borrow1", borrow, 1);
      @(negedge clk);
      start = 1'b0; a = 8'hEE; b = 8'h77;
      chk("b2b_no_gap", busy, 1);
      chk("b2b_diff_cleared", diff, 0);
      chk("b2b_borrow_hold", borrow, 1);
      lat = 0;
      for (int k = 1; k <= 30; k++) begin
         if (k > 1) @(negedge clk);
         if (done) begin
            lat = k;
            break;
         end
      end
      chk("b2b_latency", lat, 9);
      chk("b2b_diff2", diff, 8'h06);
      chk("b2b_borrow2", borrow, 0);
      chk("b2b_ovf2", ovf, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
